// File: rtl/aes_ks_pkg.sv
// Shared types and constants for the AES-128 key-schedule sequencer.
// Holds the sequencer state enum and the xtime helper used for rcon.
package aes_ks_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EMIT,
        FEED,
        WAIT,
        CAPTURE,
        DONE,
        ERR
    } ks_state_e;

    localparam int         KEY_BYTES  = 16;
    localparam int         NUM_ROUNDS = 10;
    localparam logic [7:0] RCON_INIT  = 8'h01;
    localparam logic [7:0] RCON_POLY  = 8'h1B;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant generator: loads 0x01 for round 1, then steps via xtime.
// Output is registered and clears to 0x00 on reset (round 0).
module aes_rcon_gen
    import aes_ks_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic       step_i,
    output logic [7:0] rcon_o
);

    logic [7:0] rcon_q;
    logic [7:0] rcon_d;

    always_comb begin
        rcon_d = rcon_q;
        if (load_i) begin
            rcon_d = RCON_INIT;
        end else if (step_i) begin
            rcon_d = xtime(rcon_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rcon_q <= 8'h00;
        end else begin
            rcon_q <= rcon_d;
        end
    end

    assign rcon_o = rcon_q;

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Byte-serial AES-128 key-schedule sequencer between key port, engine and datapath.
// Optional WAIT timeout is compiled in with AES_KEY_SCHED_TIMEOUT_EN.
module aes_key_sched_ctrl
    import aes_ks_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CAPTURE_SKIP   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [7:0] key_byte,
    output logic       key_ready,
    output logic       exp_din_valid,
    output logic [7:0] exp_din,
    output logic [7:0] exp_rcon,
    output logic       exp_round_complete,
    input  logic       exp_dout_valid,
    input  logic [7:0] exp_dout,
    output logic       rk_valid,
    output logic [7:0] rk_byte,
    output logic [3:0] rk_round,
    output logic       rk_last,
    input  logic       rk_ready,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int CW = $clog2(CAPTURE_SKIP + KEY_BYTES + 1);
    localparam logic [CW-1:0] CAP_FIRST = CW'(CAPTURE_SKIP);
    localparam logic [CW-1:0] CAP_LAST  = CW'(CAPTURE_SKIP + KEY_BYTES - 1);

    ks_state_e     state_q, state_d;
    logic [7:0]    key_buf_q [KEY_BYTES];
    logic [3:0]    idx_q, idx_d;
    logic [3:0]    round_q, round_d;
    logic [CW-1:0] vcnt_q, vcnt_d;

    logic       key_hs, rk_hs, in_cap, cap_wr, cap_last;
    logic [3:0] cap_idx;
    logic       rcon_load, rcon_step;
    logic       tmo_hit;

    logic       key_ready_q, key_ready_d;
    logic       din_valid_q, din_valid_d;
    logic [7:0] din_q, din_d;
    logic       rcmp_q, rcmp_d;
    logic       rk_valid_q, rk_valid_d;
    logic [7:0] rk_byte_q, rk_byte_d;
    logic [3:0] rk_round_q, rk_round_d;
    logic       rk_last_q, rk_last_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    assign key_hs   = key_valid & key_ready_q;
    assign rk_hs    = rk_valid_q & rk_ready;
    assign in_cap   = (state_q == WAIT) || (state_q == CAPTURE);
    assign cap_wr   = in_cap & exp_dout_valid & (vcnt_q >= CAP_FIRST);
    assign cap_last = cap_wr & (vcnt_q == CAP_LAST);
    assign cap_idx  = 4'(vcnt_q - CAP_FIRST);

`ifdef AES_KEY_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q;
    logic          err_q;

    // Counter is zero whenever WAIT is entered.
    always_ff @(posedge clk) begin
        if (!rst_n || state_q != WAIT) begin
            tmo_q <= '0;
        end else if (!exp_dout_valid) begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    assign tmo_hit = (state_q == WAIT) && !exp_dout_valid &&
                     (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state_d == ERR);
        end
    end

    assign err = err_q;
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            round_q <= 4'd0;
            vcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            round_q <= round_d;
            vcnt_q  <= vcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (key_hs) begin
            key_buf_q[idx_q] <= key_byte;
        end else if (cap_wr) begin
            key_buf_q[cap_idx] <= exp_dout;
        end
    end

    // idx wraps 15 -> 0 at the end of LOAD, EMIT and FEED.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        round_d   = round_q;
        vcnt_d    = vcnt_q;
        rcon_load = 1'b0;
        rcon_step = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (key_hs) begin
                    state_d = LOAD;
                    idx_d   = 4'd1;
                end
            end
            LOAD: begin
                if (key_hs) begin
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd15) begin
                        state_d = EMIT;
                        round_d = 4'd0;
                    end
                end
            end
            EMIT: begin
                if (rk_hs) begin
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd15) begin
                        if (round_q == 4'(NUM_ROUNDS)) begin
                            state_d = DONE;
                        end else begin
                            state_d   = FEED;
                            round_d   = round_q + 4'd1;
                            rcon_load = (round_q == 4'd0);
                            rcon_step = (round_q != 4'd0);
                        end
                    end
                end
            end
            FEED: begin
                idx_d = idx_q + 4'd1;
                if (idx_q == 4'd15) begin
                    state_d = WAIT;
                    vcnt_d  = '0;
                end
            end
            WAIT: begin
                if (exp_dout_valid) begin
                    state_d = CAPTURE;
                    vcnt_d  = vcnt_q + 1'b1;
                end else if (tmo_hit) begin
                    state_d = ERR;
                end
            end
            CAPTURE: begin
                if (exp_dout_valid) begin
                    vcnt_d = vcnt_q + 1'b1;
                    if (cap_last) begin
                        state_d = EMIT;
                        idx_d   = 4'd0;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        key_ready_d = (state_d == IDLE) || (state_d == LOAD);
        busy_d      = !(state_d inside {IDLE, DONE, ERR});
        done_d      = (state_d == DONE);
        rcmp_d      = (state_d == WAIT) || (state_d == CAPTURE);
        din_valid_d = (state_q == FEED);
        din_d       = (state_q == FEED) ? key_buf_q[idx_q] : 8'h00;
        rk_valid_d  = (state_q == EMIT) && !(rk_hs && idx_q == 4'd15);
        rk_byte_d   = rk_valid_d ? key_buf_q[idx_d] : 8'h00;
        rk_last_d   = rk_valid_d && (idx_d == 4'd15);
        rk_round_d  = rk_round_q;
        if (state_d == EMIT && state_q != EMIT) begin
            rk_round_d = round_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_ready_q <= 1'b0;
            din_valid_q <= 1'b0;
            din_q       <= 8'h00;
            rcmp_q      <= 1'b0;
            rk_valid_q  <= 1'b0;
            rk_byte_q   <= 8'h00;
            rk_round_q  <= 4'd0;
            rk_last_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            key_ready_q <= key_ready_d;
            din_valid_q <= din_valid_d;
            din_q       <= din_d;
            rcmp_q      <= rcmp_d;
            rk_valid_q  <= rk_valid_d;
            rk_byte_q   <= rk_byte_d;
            rk_round_q  <= rk_round_d;
            rk_last_q   <= rk_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    aes_rcon_gen u_rcon (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (rcon_load),
        .step_i (rcon_step),
        .rcon_o (exp_rcon)
    );

    assign key_ready          = key_ready_q;
    assign exp_din_valid      = din_valid_q;
    assign exp_din            = din_q;
    assign exp_round_complete = rcmp_q;
    assign rk_valid           = rk_valid_q;
    assign rk_byte            = rk_byte_q;
    assign rk_round           = rk_round_q;
    assign rk_last            = rk_last_q;
    assign busy               = busy_q;
    assign done               = done_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench: FIPS-197 key, behavioural key expansion and engine model.
// Timeout scenario runs only when AES_KEY_SCHED_TIMEOUT_EN is defined.
module tb_aes_key_sched_ctrl;

    localparam int SKIP = 1;
    localparam int LAT  = 2;
    localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [7:0] key_byte = 8'h00;
    logic       key_ready;
    logic       exp_din_valid;
    logic [7:0] exp_din;
    logic [7:0] exp_rcon;
    logic       exp_round_complete;
    logic       exp_dout_valid = 1'b0;
    logic [7:0] exp_dout = 8'h00;
    logic       rk_valid;
    logic [7:0] rk_byte;
    logic [3:0] rk_round;
    logic       rk_last;
    logic       rk_ready = 1'b1;
    logic       busy, done, err;

    int n_cmp = 0;
    int n_bad = 0;
    int eng_keys = 0;
    int eng_sent = 0;
    bit eng_silent = 1'b0;
    bit rnd_ready = 1'b0;

    logic [7:0]   rcon_tbl [10];
    logic [127:0] model_rk [11];
    logic [127:0] rec_rk [12];
    int m_round, m_pos, n_last, n_bytes;

    aes_key_sched_ctrl #(.TIMEOUT_CYCLES(8), .CAPTURE_SKIP(SKIP)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_valid(key_valid), .key_byte(key_byte), .key_ready(key_ready),
        .exp_din_valid(exp_din_valid), .exp_din(exp_din), .exp_rcon(exp_rcon),
        .exp_round_complete(exp_round_complete),
        .exp_dout_valid(exp_dout_valid), .exp_dout(exp_dout),
        .rk_valid(rk_valid), .rk_byte(rk_byte), .rk_round(rk_round),
        .rk_last(rk_last), .rk_ready(rk_ready),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [127:0] act,
                         input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r = 8'h01;
        logic [7:0] s;
        for (int i = 7; i >= 0; i--) begin
            r = gmul(r, r);
            if (i != 0) r = gmul(r, x);
        end
        s = r;
        for (int i = 0; i < 4; i++) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [127:0] key_next(input logic [127:0] k,
                                              input logic [7:0] rc);
        logic [31:0] w [4];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        t = {sbox(w[3][23:16]) ^ rc, sbox(w[3][15:8]),
             sbox(w[3][7:0]), sbox(w[3][31:24])};
        w[0] = w[0] ^ t;
        w[1] = w[1] ^ w[0];
        w[2] = w[2] ^ w[1];
        w[3] = w[3] ^ w[2];
        return {w[0], w[1], w[2], w[3]};
    endfunction

    // Reference engine: collects 16 din bytes, replies SKIP junk + 16 bytes.
    initial begin
        logic [127:0] kin;
        logic [127:0] kout;
        logic [8:0]   q [$];
        logic [8:0]   e;
        int n = 0;
        int dly = 0;
        kin = '0;
        forever begin
            @(posedge clk); #1;
            exp_dout_valid = 1'b0;
            exp_dout = 8'h00;
            if (!rst_n) begin
                n = 0; q.delete(); eng_keys = 0; eng_sent = 0;
            end else begin
                if (exp_din_valid) begin
                    kin[127-8*n -: 8] = exp_din;
                    n++;
                    if (n == 16) begin
                        n = 0;
                        if (eng_keys < 10)
                            check("exp_rcon", exp_rcon, rcon_tbl[eng_keys]);
                        else
                            check("extra_feed", eng_keys, 10);
                        kout = key_next(kin, exp_rcon);
                        q.delete();
                        for (int s = 0; s < SKIP; s++) q.push_back({1'b1, 8'hEE});
                        for (int i = 0; i < 16; i++) begin
                            if (i == 8) q.push_back(9'h000);
                            q.push_back({1'b1, kout[127-8*i -: 8]});
                        end
                        eng_keys++;
                        eng_sent = 0;
                        dly = LAT;
                    end
                end
                if (q.size() > 0 && exp_round_complete && !eng_silent) begin
                    if (dly > 0) dly--;
                    else begin
                        e = q.pop_front();
                        exp_dout_valid = e[8];
                        exp_dout = e[7:0];
                        if (e[8]) eng_sent++;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            rk_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Round-key stream checker against the model schedule.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_round = 0; m_pos = 0; n_last = 0; n_bytes = 0;
            for (int i = 0; i < 12; i++) rec_rk[i] = '0;
        end else if (rk_valid) begin
            if (m_round > 10) begin
                check("extra_rk_byte", m_round, 10);
            end else begin
                check("rk_byte", rk_byte, model_rk[m_round][127-8*m_pos -: 8]);
                check("rk_round", rk_round, m_round);
                check("rk_last", rk_last, m_pos == 15);
                if (rk_ready) begin
                    rec_rk[m_round][127-8*m_pos -: 8] = rk_byte;
                    if (rk_last) n_last++;
                    n_bytes++;
                    m_pos++;
                    if (m_pos == 16) begin
                        m_pos = 0;
                        m_round++;
                    end
                end
            end
        end
    end

    task automatic load_key(input logic [127:0] k);
        int g;
        for (int i = 0; i < 16; i++) begin
            key_valid = 1'b1;
            key_byte = k[127-8*i -: 8];
            g = 0;
            while (!key_ready && g < 50) begin
                @(posedge clk); #1;
                g++;
            end
            if (g >= 50) check("key_ready_timeout", 0, 1);
            @(posedge clk); #1;
        end
        key_valid = 1'b0;
    endtask

    task automatic wait_done();
        int g = 0;
        while (!done && g < 5000) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 5000) check("done_timeout", 0, 1);
    endtask

    task automatic do_reset(input string nm);
        key_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check(nm, {key_ready, exp_din_valid, exp_din, exp_rcon,
                   exp_round_complete, rk_valid, rk_byte, rk_round,
                   rk_last, busy, done, err}, 36'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_key_ready", key_ready, 1'b1);
        check("idle_busy", busy, 1'b0);
    endtask

    task automatic finish_run(input string nm);
        $display("checking run %s", nm);
        check("done", done, 1'b1);
        check("busy_done", busy, 1'b0);
        check("key_ready_done", key_ready, 1'b0);
        check("err_clear", err, 1'b0);
        check("rk_last_count", n_last, 11);
        check("rk_byte_count", n_bytes, 176);
        check("round0_key", rec_rk[0], KEY);
        check("round1_key", rec_rk[1], R1);
        check("round10_key", rec_rk[10], R10);
        check("rcon_rounds", eng_keys, 10);
        key_valid = 1'b1;
        key_byte = 8'h5a;
        repeat (5) @(posedge clk);
        #1;
        key_valid = 1'b0;
        check("done_holds", {done, key_ready, busy}, 3'b100);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int cnt;
        rcon_tbl = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                     8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        model_rk[0] = KEY;
        for (int r = 1; r <= 10; r++)
            model_rk[r] = key_next(model_rk[r-1], rcon_tbl[r-1]);
        check("model_sbox00", sbox(8'h00), 8'h63);
        check("model_sbox53", sbox(8'h53), 8'hed);
        check("model_round1", model_rk[1], R1);
        check("model_round10", model_rk[10], R10);

        do_reset("reset_outputs");
        load_key(KEY);
        wait_done();
        finish_run("ready_high");

        do_reset("reset_outputs_b");
        rnd_ready = 1'b1;
        load_key(KEY);
        key_valid = 1'b1;
        key_byte = 8'hFF;
        wait_done();
        key_valid = 1'b0;
        finish_run("ready_random");
        rnd_ready = 1'b0;

        do_reset("reset_outputs_c");
        load_key(KEY);
        g = 0;
        while (!(eng_keys == 4 && eng_sent >= 5) && g < 5000) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 5000) check("round4_capture_timeout", 0, 1);
        check("in_capture", {exp_round_complete, busy}, 2'b11);
        do_reset("reset_mid_capture");
        load_key(KEY);
        wait_done();
        finish_run("reload");

`ifdef AES_KEY_SCHED_TIMEOUT_EN
        do_reset("reset_outputs_t");
        eng_silent = 1'b1;
        load_key(KEY);
        g = 0;
        cnt = 0;
        while (!err && g < 2000) begin
            @(posedge clk); #1;
            if (exp_round_complete) cnt++;
            g++;
        end
        if (g >= 2000) check("err_timeout", 0, 1);
        check("tmo_wait_cycles", cnt, 8);
        check("tmo_flags", {err, busy, exp_round_complete}, 3'b100);
        repeat (10) @(posedge clk);
        #1;
        check("tmo_holds", {err, busy, done}, 3'b100);
        eng_silent = 1'b0;
        do_reset("reset_after_err");
`else
        cnt = 0;
        g = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_key_sched_ctrl.md
# aes_key_sched_ctrl

Sequencer for the byte-serial AES-128 key-expansion engine. It accepts the 16-byte cipher key and emits it as round key 0. For rounds 1–10 it feeds the previous round key and the round constant to the engine, captures the 16 returned bytes, and streams each round key to the cipher datapath over a valid/ready byte handshake. It sits between the key input port, the key-expansion engine and the round datapath.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles in WAIT with no engine output (only used when the timeout feature is compiled in).
- CAPTURE_SKIP, 1: number of leading exp_dout_valid cycles discarded before capture begins.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- key_valid  in  1  cipher key byte valid.
- key_byte  in  8  cipher key byte; byte 0 first.
- key_ready  out  1  high in IDLE and LOAD only.
- exp_din_valid  out  1  byte strobe to the engine's din enable.
- exp_din  out  8  key byte to the engine.
- exp_rcon  out  8  round constant for the current round; stable from FEED through CAPTURE.
- exp_round_complete  out  1  release strobe to the engine.
- exp_dout_valid  in  1  engine output strobe.
- exp_dout  in  8  engine output byte.
- rk_valid  out  1  round-key byte valid.
- rk_byte  out  8  round-key byte.
- rk_round  out  4  round index, 0–10.
- rk_last  out  1  high with byte 15 of each round key.
- rk_ready  in  1  cipher accepts the byte.
- busy  out  1  high whenever state is not IDLE, DONE or ERR.
- done  out  1  high in DONE.
- err  out  1  sticky timeout flag.

## Operation
- States:
  - IDLE → LOAD on the first key_valid handshake; that byte is stored.
  - LOAD: stores 16 bytes into key_buf[0..15]. After byte 15: set round=0 and go to EMIT.
  - EMIT: presents key_buf[idx] while rk_valid=1. idx advances only on rk_valid & rk_ready. After byte 15 is accepted:
    - if round==10, go to DONE;
    - otherwise round += 1 and go to FEED.
  - FEED: drives key_buf[0..15] on exp_din, one byte per cycle, exp_din_valid=1 for exactly 16 consecutive cycles. Then go to WAIT.
  - WAIT: exp_round_complete=1. The first exp_dout_valid moves to CAPTURE; that cycle counts toward CAPTURE_SKIP.
  - CAPTURE: exp_round_complete stays 1. Discards the first CAPTURE_SKIP valid cycles, then writes the next 16 valid bytes to key_buf[0..15] in order. Valid cycles after byte 15 are ignored. Then go to EMIT.
  - DONE: holds until rst_n. It ignores key_valid, and key_ready=0.
  - ERR: timeout only; holds until rst_n.
- exp_rcon sequence for rounds 1–10: 01,02,04,08,10,20,40,80,1B,36. It is generated by xtime: shift left, and XOR with 0x1B when bit 7 is set. It is 0x00 in round 0.
- No capture backpressure: the engine output is consumed at line rate. key_buf is overwritten only in CAPTURE, after EMIT of the previous key has fully completed.
- key_valid during FEED/WAIT/CAPTURE/EMIT is ignored (key_ready=0).

## Timing
- Reset values: every output is 0, state=IDLE, round=0, idx=0, err=0.
- rst_n low mid-operation aborts on the next edge. exp_din_valid and exp_round_complete drop in that same edge. Re-arming the engine is the system's responsibility.
- Round-key bytes are registered outputs. Byte 0 is valid the cycle after entering EMIT. Back-to-back acceptance gives 1 byte/cycle.
- FEED start to first exp_din_valid is 1 cycle; FEED lasts exactly 16 cycles.
- rk_round changes only on the entry edge into EMIT.
- Minimum time from key load to DONE, with rk_ready always high: 16 load + 11×17 emit + 10×(16 feed + engine latency + 16 + CAPTURE_SKIP).

## Configuration
- AES_KEY_SCHED_TIMEOUT_EN defined:
  - A counter runs in WAIT and is cleared on state entry.
  - Reaching TIMEOUT_CYCLES with no exp_dout_valid moves to ERR: err=1, busy=0, exp_round_complete=0.
- Undefined: WAIT waits indefinitely, err is tied to 0, and no counter is synthesized.

## Structure
- Package aes_ks_pkg holds:
  - the state enum (IDLE, LOAD, EMIT, FEED, WAIT, CAPTURE, DONE, ERR);
  - the constants KEY_BYTES=16, NUM_ROUNDS=10, RCON_INIT=8'h01, RCON_POLY=8'h1B.
- One sub-module, aes_rcon_gen, handles rcon:
  - load to 0x01 and step via xtime on each round increment;
  - output registered.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c with a reference engine model:
  - round 0 streams the key unchanged;
  - round 1 = a0fafe1788542cb123a339392a6c7605;
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
  - done=1 afterwards.
- rk_ready toggled randomly 50%: byte order and rk_round are unchanged, and rk_last appears on exactly 11 bytes.
- exp_rcon is observed at each FEED: the sequence is 01,02,04,08,10,20,40,80,1B,36.
- CAPTURE_SKIP=1 with the engine asserting 17 valid cycles: the first byte is dropped and the captured key matches the model.
- rst_n asserted during round 4 CAPTURE: next cycle all outputs are 0 and state is IDLE. A reloaded key reproduces the first vector.
- With AES_KEY_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=8, the engine is silent: err=1 after 8 WAIT cycles, busy=0, and the state holds until reset.
